// File: rtl/md_ctrl_pkg.sv
// Shared constants for the MIPS multiply/divide controller: op codes, widths, default latencies.
// MD_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package md_ctrl_pkg;

  localparam int MD_OP_W = 4;
  typedef logic [MD_OP_W-1:0] md_op_t;

  localparam md_op_t MD_NONE  = 4'd0;
  localparam md_op_t MD_MULT  = 4'd1;
  localparam md_op_t MD_MULTU = 4'd2;
  localparam md_op_t MD_DIV   = 4'd3;
  localparam md_op_t MD_DIVU  = 4'd4;
  localparam md_op_t MD_MFHI  = 4'd5;
  localparam md_op_t MD_MFLO  = 4'd6;
  localparam md_op_t MD_MTHI  = 4'd7;
  localparam md_op_t MD_MTLO  = 4'd8;
  localparam md_op_t MD_MADD  = 4'd9;
  localparam md_op_t MD_MADDU = 4'd10;
  localparam md_op_t MD_MSUB  = 4'd11;
  localparam md_op_t MD_MSUBU = 4'd12;

  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;

  // Codes outside the supported set collapse to MD_NONE so nothing downstream sees them.
  function automatic md_op_t md_decode(input md_op_t op);
    md_op_t r;
    r = MD_NONE;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
      MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO: r = op;
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = op;
`endif
      default: r = MD_NONE;
    endcase
    return r;
  endfunction

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Expects an already-decoded op.
  function automatic logic md_is_multi(input md_op_t op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
`ifdef MD_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

endpackage

// File: rtl/md_ctrl_alu.sv
// md_alu: combinational HI/LO result generator for the multiply/divide controller.
// MD_MADD_EN adds the multiply-accumulate/subtract paths.
module md_alu
  import md_ctrl_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] next_hi,
  output logic [31:0] next_lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_mag_safe;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide goes through magnitudes so 0x80000000 / -1 cannot overflow.
  assign a_mag      = a[31] ? (~a + 32'd1) : a;
  assign b_mag      = b[31] ? (~b + 32'd1) : b;
  assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign b_safe     = (b == 32'd0) ? 32'd1 : b;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;

  assign div_zero = md_is_div(op) && (b == 32'd0);

  always_comb begin
    next_hi = hi;
    next_lo = lo;
    case (op)
      MD_MULT:  {next_hi, next_lo} = prod_s;
      MD_MULTU: {next_hi, next_lo} = prod_u;
      MD_DIV: begin
        next_lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        next_hi = a[31] ? (~r_mag + 32'd1) : r_mag;
      end
      MD_DIVU: begin
        next_lo = a / b_safe;
        next_hi = a % b_safe;
      end
`ifdef MD_MADD_EN
      MD_MADD:  {next_hi, next_lo} = {hi, lo} + prod_s;
      MD_MADDU: {next_hi, next_lo} = {hi, lo} + prod_u;
      MD_MSUB:  {next_hi, next_lo} = {hi, lo} - prod_s;
      MD_MSUBU: {next_hi, next_lo} = {hi, lo} - prod_u;
`endif
      default: begin
        next_hi = hi;
        next_lo = lo;
      end
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer beside the E stage: latches operands, times the latency, commits HI/LO.
// MD_MADD_EN enables the accumulate ops (decoded in md_ctrl_pkg, computed in md_alu).
//
//   state | meaning
//   IDLE  | no op in flight, Busy=0; accepts MD ops and MTHI/MTLO
//   RUN   | multi-cycle op in flight, Busy=1; commits when counter reaches 1
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        IsMDInsD,
  output logic        Busy,
  output logic        MDStall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] MUL_CNT = MUL_LAT[3:0];
  localparam logic [3:0] DIV_CNT = DIV_LAT[3:0];

  logic [0:0]  state;
  logic [3:0]  cnt;
  md_op_t      op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  md_op_t      op_in;
  logic        in_multi;
  logic [31:0] next_hi;
  logic [31:0] next_lo;
  logic        div_zero;

  assign op_in    = md_decode(MDOp);
  assign in_multi = md_is_multi(op_in);

  md_alu u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hi       (hi_q),
    .lo       (lo_q),
    .next_hi  (next_hi),
    .next_lo  (next_lo),
    .div_zero (div_zero)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      op_q  <= MD_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (in_multi) begin
              state <= S_RUN;
              cnt   <= md_is_div(op_in) ? DIV_CNT : MUL_CNT;
              op_q  <= op_in;
              a_q   <= A;
              b_q   <= B;
            end else if (op_in == MD_MTHI) begin
              hi_q <= A;
            end else if (op_in == MD_MTLO) begin
              lo_q <= A;
            end
          end
        end
        S_RUN: begin
          // Start is ignored here; MDStall keeps the next MD op out of E.
          if (cnt == 4'd1) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            if (!div_zero) begin
              hi_q <= next_hi;
              lo_q <= next_lo;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign Busy    = (state == S_RUN);
  assign MDStall = IsMDInsD && (Busy || (Start && in_multi));
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign MDOut   = (op_in == MD_MFHI) ? hi_q :
                   (op_in == MD_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed cases with literal expectations plus randomized traffic
// compared every cycle against an arithmetic model of HI/LO and the busy window.
module tb_md_ctrl;

  localparam int unsigned MUL_L = 5;
  localparam int unsigned DIV_L = 10;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        IsMDInsD;
  logic        Busy;
  logic        MDStall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  md_ctrl #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .MDOp     (MDOp),
    .A        (A),
    .B        (B),
    .IsMDInsD (IsMDInsD),
    .Busy     (Busy),
    .MDStall  (MDStall),
    .HI       (HI),
    .LO       (LO),
    .MDOut    (MDOut)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  int          m_left = 0;
  logic [3:0]  m_op = 4'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;

  function automatic logic [3:0] m_norm(input logic [3:0] op);
    if (op <= 4'd8) return op;
`ifdef MD_MADD_EN
    if (op <= 4'd12) return op;
`endif
    return 4'd0;
  endfunction

  function automatic bit m_multi(input logic [3:0] op);
    logic [3:0] n;
    n = m_norm(op);
    return (n >= 4'd1 && n <= 4'd4) || (n >= 4'd9);
  endfunction

  task automatic m_commit();
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] p, acc;
    sa = longint'($signed(m_a));
    sb = longint'($signed(m_b));
    ua = {32'd0, m_a};
    ub = {32'd0, m_b};
    acc = {m_hi, m_lo};
    case (m_op)
      4'd1: begin p = sa * sb; {m_hi, m_lo} = p; end
      4'd2: begin p = ua * ub; {m_hi, m_lo} = p; end
      4'd3: if (m_b != 0) begin
        q = sa / sb; r = sa % sb;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      4'd4: if (m_b != 0) begin
        m_lo = m_a / m_b; m_hi = m_a % m_b;
      end
      4'd9:  begin p = sa * sb; acc = acc + p; {m_hi, m_lo} = acc; end
      4'd10: begin p = ua * ub; acc = acc + p; {m_hi, m_lo} = acc; end
      4'd11: begin p = sa * sb; acc = acc - p; {m_hi, m_lo} = acc; end
      4'd12: begin p = ua * ub; acc = acc - p; {m_hi, m_lo} = acc; end
      default: ;
    endcase
  endtask

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_op = 0; m_a = 0; m_b = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) m_commit();
    end else if (Start) begin
      if (m_multi(MDOp)) begin
        m_op = m_norm(MDOp); m_a = A; m_b = B;
        m_left = (m_op == 4'd3 || m_op == 4'd4) ? int'(DIV_L) : int'(MUL_L);
      end else if (m_norm(MDOp) == 4'd7) m_hi = A;
      else if (m_norm(MDOp) == 4'd8) m_lo = A;
    end
  end

  always @(negedge Clk) begin
    if (chk_on && Reset_n) begin
      chk("busy", {31'd0, Busy}, {31'd0, m_left > 0});
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
      chk("stall", {31'd0, MDStall},
          {31'd0, IsMDInsD && (m_left > 0 || (Start && m_multi(MDOp)))});
      chk("mdout", MDOut, (MDOp == 4'd5) ? m_hi : (MDOp == 4'd6) ? m_lo : 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    Start = 1'b1; MDOp = op; A = a; B = b;
    step();
    Start = 1'b0; MDOp = 4'd0;
    n = 0;
    while (Busy && n < 40) begin
      n++;
      step();
    end
    if (n >= 40) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n;
    Reset_n = 1'b1; Start = 1'b0; MDOp = 4'd0; A = 0; B = 0; IsMDInsD = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    #10 Reset_n = 1'b1;
    step();
    chk_on = 1'b1;

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, n);
    chk("mult_busy_cycles", n, 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    MDOp = 4'd6; #1;
    chk("mflo_out", MDOut, 32'hFFFF_FFFA);
    MDOp = 4'd0; step();

    run_op(4'd4, 32'd17, 32'd5, n);
    chk("divu_busy_cycles", n, 32'd10);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd2);
    run_op(4'd3, 32'hFFFF_FFEF, 32'd5, n);
    chk("div_neg_lo", LO, 32'hFFFF_FFFD);
    chk("div_neg_hi", HI, 32'hFFFF_FFFE);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("div_ovf_lo", LO, 32'h8000_0000);
    chk("div_ovf_hi", HI, 32'd0);

    run_op(4'd7, 32'h11, 32'd0, n);
    run_op(4'd8, 32'h22, 32'd0, n);
    run_op(4'd3, 32'd99, 32'd0, n);
    chk("div0_busy_cycles", n, 32'd10);
    chk("div0_hi", HI, 32'h11);
    chk("div0_lo", LO, 32'h22);

    IsMDInsD = 1'b1;
    Start = 1'b1; MDOp = 4'd2; A = 32'd7; B = 32'd9; #1;
    chk("stall_start", {31'd0, MDStall}, 32'd1);
    step();
    Start = 1'b0; MDOp = 4'd0;
    n = 0;
    while (Busy && n < 40) begin
      chk("stall_busy", {31'd0, MDStall}, 32'd1);
      n++;
      step();
    end
    chk("stall_busy_cycles", n, 32'd5);
    chk("stall_after", {31'd0, MDStall}, 32'd0);
    chk("multu_lo", LO, 32'd63);
    IsMDInsD = 1'b0;
    Start = 1'b1; MDOp = 4'd2; A = 32'd3; B = 32'd3; #1;
    chk("nostall_start", {31'd0, MDStall}, 32'd0);
    step(); Start = 1'b0; MDOp = 4'd0;
    while (Busy && n < 80) begin
      chk("nostall_busy", {31'd0, MDStall}, 32'd0);
      n++;
      step();
    end

    run_op(4'd7, 32'hDEAD_BEEF, 32'd0, n);
    chk("mthi_busy_cycles", n, 32'd0);
    chk("mthi_hi", HI, 32'hDEAD_BEEF);

    Start = 1'b1; MDOp = 4'd1; A = 32'd6; B = 32'd7;
    step();
    MDOp = 4'd7; A = 32'h5555;
    step();
    MDOp = 4'd3; A = 32'd1; B = 32'd1;
    step();
    Start = 1'b0; MDOp = 4'd0;
    n = 0;
    while (Busy && n < 40) begin n++; step(); end
    chk("run_ignore_hi", HI, 32'd0);
    chk("run_ignore_lo", LO, 32'd42);

    run_op(4'd7, 32'h1234, 32'd0, n);
    Start = 1'b1; MDOp = 4'd3; A = 32'd100; B = 32'd7;
    step();
    Start = 1'b0; MDOp = 4'd0;
    step(); step(); step();
    #2 Reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd42 - 32'd42);
    #3 Reset_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("abort_no_commit_hi", HI, 32'd0);
    chk("abort_no_commit_lo", LO, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      Start    = ($urandom_range(0, 3) == 0);
      MDOp     = 4'($urandom_range(0, 15));
      A        = rnd_operand();
      B        = rnd_operand();
      IsMDInsD = $urandom_range(0, 1) == 1;
      step();
    end
    Start = 1'b0; MDOp = 4'd0;
    for (int i = 0; i < 20; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide unit controller for the 5-stage MIPS pipeline. Sits beside the E stage and sequences the shared multi-cycle HI/LO datapath.
- Accepts mult/div/move operations issued from E and latches their operands.
- Counts out the fixed operation latency and commits results to HI/LO.
- Generates the MDStall that holds D and bubbles the E pipeline register while an MD instruction in D would conflict.

Parameters:
- MUL_LAT, 5, cycles Busy stays high for MULT/MULTU (and MADD-class ops); legal range 1..15.
- DIV_LAT, 10, cycles Busy stays high for DIV/DIVU; legal range 1..15.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  the E-stage instruction is an MD op; qualifies MDOp.
- MDOp  in  4  operation code (package constants).
- A  in  32  rs operand (forwarded value in E).
- B  in  32  rt operand (forwarded value in E).
- IsMDInsD  in  1  the instruction in D is any MD op, including mfhi/mflo.
- Busy  out  1  a multi-cycle operation is in flight.
- MDStall  out  1  IsMDInsD && (Busy || (Start && op is multi-cycle)).
- HI  out  32  HI register.
- LO  out  32  LO register.
- MDOut  out  32  HI when MDOp==MD_MFHI, LO when MDOp==MD_MFLO, else 0. Combinational; E-stage result for mfhi/mflo.

Behaviour:
- Reset (asynchronous, Reset_n low):
  - State IDLE, counter 0.
  - HI, LO, Busy and the operand latches all 0.
  - Takes effect mid-operation and aborts it: no HI/LO commit.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1.
- IDLE -> RUN: on a rising edge with Start=1 and MDOp a multi-cycle op.
  - A, B and MDOp are latched.
  - Counter loaded with MUL_LAT or DIV_LAT.
- RUN: the counter decrements each edge.
  - The edge where the counter equals 1 commits the result to HI/LO and returns to IDLE.
  - Busy is therefore high for exactly LAT cycles after the accepting edge.
- MTHI/MTLO with Start=1 in IDLE: HI (resp. LO) <= A at that edge; no Busy.
- MFHI/MFLO never change state.
- Start while in RUN: ignored, no state change. The pipeline cannot produce this because MDStall keeps the next MD op in D.
- MDStall is combinational. It is asserted the same cycle a multi-cycle op enters E, so a following MD op in D is held.
- MULT: signed 32x32 -> 64. MULTU: unsigned. Commit {HI,LO} = product.
- DIV (signed):
  - LO = quotient truncated toward zero; HI = remainder, sign of dividend.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: full DIV_LAT busy period runs, but HI/LO are left unchanged at commit.
- Result computation may use the combinational `*` and `/` operators on the latched operands. The counter only models latency.
- MDOp values outside the defined set are treated as MD_NONE.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: ops MADD, MADDU, MSUB and MSUBU are accepted with MUL_LAT latency.
  - Commit is {HI,LO} <= {HI,LO} +/- product, 64-bit wrap-around.
  - The accumulator uses the HI/LO value at commit time.
- Undefined: those codes decode as MD_NONE, and the accumulate logic is absent.

Decomposition:
- Shared header (`header.v` constants), holding:
  - MD op codes: MD_NONE 0, MD_MULT 1, MD_MULTU 2, MD_DIV 3, MD_DIVU 4, MD_MFHI 5, MD_MFLO 6, MD_MTHI 7, MD_MTLO 8, MD_MADD 9, MD_MADDU 10, MD_MSUB 11, MD_MSUBU 12.
  - The MD op width (4).
  - Default latencies.
- One natural sub-module, md_alu: purely combinational. Takes latched op, A, B, HI and LO; produces {nextHI, nextLO} plus a div-by-zero flag. It keeps the arithmetic separate from the sequencing FSM.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MDOut with MD_MFLO = 0xFFFFFFFA.
- DIVU A=17, B=5 -> Busy 10 cycles, then LO=3, HI=2. DIV A=-17 (0xFFFFFFEF), B=5 -> LO=0xFFFFFFFD, HI=0xFFFFFFFE.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. DIV with B=0 and prior HI=0x11, LO=0x22 -> Busy 10 cycles, HI/LO stay 0x11/0x22.
- MULTU Start with IsMDInsD=1 -> MDStall=1 that cycle and all 5 busy cycles, 0 the cycle after. IsMDInsD=0 -> MDStall never asserted.
- MTHI A=0xDEADBEEF in IDLE -> HI=0xDEADBEEF next edge, Busy stays 0. Start during RUN -> ignored, commit unaffected.
- DIV started, Reset_n pulled low at busy cycle 4 -> Busy, HI and LO are 0 immediately (asynchronous), with no later commit.
